branch_prediction_unit: RTL and testbench

- Parametrised successor to the fetch-stage predictor/BTB pair.
- Direct-mapped, tagged branch target buffer with a per-entry saturating counter, so each branch keeps its own history instead of sharing one global counter.
- Lookup is combinational in Fetch. Update and mispredict detection run in Execute, and the block produces the Execute-stage redirect PC.
- Replaces the separate predictor and BTB inside fetch.

---
 rtl/branch_prediction_unit_pkg.sv | 11 +
 rtl/branch_prediction_unit_sat_counter.sv | 15 +
 rtl/branch_prediction_unit.sv | 85 ++++++++
 tb/tb_branch_prediction_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_prediction_unit_pkg.sv
// branch_prediction_unit_pkg: shared counter encodings and default sizes for the branch prediction unit
package branch_prediction_unit_pkg;
  typedef enum logic [1:0] {
    STRONGLY_UNTAKEN = 2'b00,
    WEAKLY_UNTAKEN   = 2'b01,
    WEAKLY_TAKEN     = 2'b10,
    STRONGLY_TAKEN   = 2'b11
  } bp_ctr_e;
  localparam int BPU_DEFAULT_ENTRIES = 32;
  localparam int BPU_DEFAULT_CTR_W   = 2;
endpackage

// File: rtl/branch_prediction_unit_sat_counter.sv
// sat_counter: combinational saturating inc/dec of a CTR_W-bit counter
//   ctr in  current value
//   up  in  1 = increment (taken), 0 = decrement (not taken)
//   nxt out next value, held at all-ones / zero when saturated
module sat_counter
  import branch_prediction_unit_pkg::*;
#(
  parameter int CTR_W = BPU_DEFAULT_CTR_W
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             up,
  output logic [CTR_W-1:0] nxt
);
  always_comb nxt = up ? ((&ctr) ? ctr : ctr + 1'b1) : ((|ctr) ? ctr - 1'b1 : ctr);
endmodule

// File: rtl/branch_prediction_unit.sv
// branch_prediction_unit: direct-mapped tagged BTB with per-entry saturating counters
//   CLK/RST                     clock, synchronous active-high reset
//   PC_F -> Predict_Taken_F/Target_F   combinational fetch lookup
//   Update_En_E, PC_E, Branch_Taken_E, PC_Target_E   execute-stage resolution, updates the BTB
//   Predict_Taken_E/Target_E    prediction carried down to execute
//   Mispredict_E, Redirect_PC_E execute-stage redirect
//   BPU_STATS_EN: adds Branch_Count and Mispredict_Count saturating event counters
module branch_prediction_unit
  import branch_prediction_unit_pkg::*;
#(
  parameter int ENTRIES = BPU_DEFAULT_ENTRIES,
  parameter int CTR_W   = BPU_DEFAULT_CTR_W,
  parameter int XLEN    = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] PC_F,
  output logic            Predict_Taken_F,
  output logic [XLEN-1:0] Predict_Target_F,
  input  logic            Update_En_E,
  input  logic [XLEN-1:0] PC_E,
  input  logic            Branch_Taken_E,
  input  logic [XLEN-1:0] PC_Target_E,
  input  logic            Predict_Taken_E,
  input  logic [XLEN-1:0] Predict_Target_E,
  output logic            Mispredict_E,
`ifdef BPU_STATS_EN
  output logic [XLEN-1:0] Redirect_PC_E,
  output logic [31:0]     Branch_Count,
  output logic [31:0]     Mispredict_Count
`else
  output logic [XLEN-1:0] Redirect_PC_E
`endif
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [XLEN-1:0]    targets [ENTRIES];
  logic [CTR_W-1:0]   ctrs    [ENTRIES];
  logic [IDX_W-1:0]   idx_f, idx_e;
  logic               hit_f, hit_e;
  logic [CTR_W-1:0]   ctr_nxt;
  logic               unused_pc_bits;
  assign unused_pc_bits = ^PC_F[1:0];
  assign idx_f = PC_F[IDX_W+1:2];
  assign idx_e = PC_E[IDX_W+1:2];
  assign hit_f = valid[idx_f] && tags[idx_f] == PC_F[XLEN-1:IDX_W+2];
  assign hit_e = valid[idx_e] && tags[idx_e] == PC_E[XLEN-1:IDX_W+2];
  assign Predict_Taken_F  = hit_f && ctrs[idx_f][CTR_W-1];
  assign Predict_Target_F = hit_f ? targets[idx_f] : '0;
  assign Mispredict_E  = Update_En_E && (Predict_Taken_E != Branch_Taken_E ||
                         (Branch_Taken_E && Predict_Target_E != PC_Target_E));
  assign Redirect_PC_E = Branch_Taken_E ? PC_Target_E : PC_E + XLEN'(4);
  sat_counter #(.CTR_W(CTR_W)) u_ctr (.ctr(ctrs[idx_e]), .up(Branch_Taken_E), .nxt(ctr_nxt));
  // A not-taken miss leaves the entry alone; any other update writes valid and counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctrs[i] <= CTR_INIT;
    end else if (Update_En_E && (hit_e || Branch_Taken_E)) begin
      valid[idx_e] <= 1'b1;
      ctrs[idx_e]  <= hit_e ? ctr_nxt : CTR_INIT;
    end
  end
  // Tags and targets need no reset; a taken outcome (re)writes both, which also allocates on a miss.
  always_ff @(posedge CLK) begin
    if (!RST && Update_En_E && Branch_Taken_E) begin
      tags[idx_e]    <= PC_E[XLEN-1:IDX_W+2];
      targets[idx_e] <= PC_Target_E;
    end
  end
`ifdef BPU_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      Branch_Count     <= '0;
      Mispredict_Count <= '0;
    end else begin
      if (Update_En_E && Branch_Count != '1) Branch_Count <= Branch_Count + 1'b1;
      if (Mispredict_E && Mispredict_Count != '1) Mispredict_Count <= Mispredict_Count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_prediction_unit.sv
// tb_branch_prediction_unit: directed self-checking bench for branch_prediction_unit
module tb_branch_prediction_unit;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] PC_F = '0;
  logic        Predict_Taken_F;
  logic [31:0] Predict_Target_F;
  logic        Update_En_E = 1'b0;
  logic [31:0] PC_E = '0;
  logic        Branch_Taken_E = 1'b0;
  logic [31:0] PC_Target_E = '0;
  logic        Predict_Taken_E = 1'b0;
  logic [31:0] Predict_Target_E = '0;
  logic        Mispredict_E;
  logic [31:0] Redirect_PC_E;
`ifdef BPU_STATS_EN
  logic [31:0] Branch_Count, Mispredict_Count;
`endif
  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  branch_prediction_unit dut (
    .CLK(CLK), .RST(RST), .PC_F(PC_F),
    .Predict_Taken_F(Predict_Taken_F), .Predict_Target_F(Predict_Target_F),
    .Update_En_E(Update_En_E), .PC_E(PC_E), .Branch_Taken_E(Branch_Taken_E),
    .PC_Target_E(PC_Target_E), .Predict_Taken_E(Predict_Taken_E),
    .Predict_Target_E(Predict_Target_E), .Mispredict_E(Mispredict_E),
`ifdef BPU_STATS_EN
    .Redirect_PC_E(Redirect_PC_E),
    .Branch_Count(Branch_Count), .Mispredict_Count(Mispredict_Count)
`else
    .Redirect_PC_E(Redirect_PC_E)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    Update_En_E = 1'b1; PC_E = pc; Branch_Taken_E = taken; PC_Target_E = tgt;
    Predict_Taken_E = ptk; Predict_Target_E = ptgt;
    tick();
    Update_En_E = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic exp_tk,
                      input logic [31:0] exp_tgt);
    PC_F = pc;
    #1;
    checks++;
    if (Predict_Taken_F !== exp_tk) begin
      errors++;
      $display("FAIL %s taken: got %b want %b", name, Predict_Taken_F, exp_tk);
    end
    checks++;
    if (Predict_Target_F !== exp_tgt) begin
      errors++;
      $display("FAIL %s target: got %h want %h", name, Predict_Target_F, exp_tgt);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    look("reset_0x40", 32'h40, 1'b0, 32'h0);
    Predict_Taken_E = 1'b1; Branch_Taken_E = 1'b0;
    #1;
    checks++;
    if (Mispredict_E !== 1'b0) begin
      errors++;
      $display("FAIL reset_mispredict: got %b want 0", Mispredict_E);
    end
    Predict_Taken_E = 1'b0;
  endtask

  task automatic test_allocate();
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    look("alloc_0x40", 32'h40, 1'b1, 32'h100);
  endtask

  task automatic test_saturation();
    logic [2:0] nt_exp;
    logic [3:0] t_exp;
    nt_exp = 3'b000;
    t_exp  = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
      look($sformatf("sat_nt%0d", i), 32'h40, nt_exp[i], 32'h100);
    end
    for (int i = 0; i < 4; i++) begin
      upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
      look($sformatf("sat_t%0d", i), 32'h40, t_exp[i], 32'h100);
    end
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    look("sat_top_nt", 32'h40, 1'b1, 32'h100);
  endtask

  task automatic test_aliasing();
    look("alias_c0_miss", 32'hC0, 1'b0, 32'h0);
    upd(32'hC0, 1'b1, 32'h200, 1'b0, 32'h0);
    look("alias_40_evicted", 32'h40, 1'b0, 32'h0);
    look("alias_c0_hit", 32'hC0, 1'b1, 32'h200);
  endtask

  task automatic test_mispredict();
    logic        en   [5];
    logic        ptk  [5];
    logic [31:0] ptgt [5];
    logic        btk  [5];
    logic [31:0] tgt  [5];
    logic [31:0] pc   [5];
    logic        e_mp [5];
    logic [31:0] e_rd [5];
    en = '{1, 1, 1, 1, 0};
    ptk = '{1, 1, 1, 0, 1};
    ptgt = '{32'h100, 32'h100, 32'h200, 32'h0, 32'h0};
    btk = '{1, 0, 1, 0, 0};
    tgt = '{32'h104, 32'h0, 32'h200, 32'h0, 32'h0};
    pc = '{32'h40, 32'h40, 32'h40, 32'hFFFF_FFFC, 32'h40};
    e_mp = '{1, 1, 0, 0, 0};
    e_rd = '{32'h104, 32'h44, 32'h200, 32'h0, 32'h44};
    for (int i = 0; i < 5; i++) begin
      Update_En_E = en[i]; Predict_Taken_E = ptk[i]; Predict_Target_E = ptgt[i];
      Branch_Taken_E = btk[i]; PC_Target_E = tgt[i]; PC_E = pc[i];
      #1;
      checks++;
      if (Mispredict_E !== e_mp[i]) begin
        errors++;
        $display("FAIL mp%0d mispredict: got %b want %b", i, Mispredict_E, e_mp[i]);
      end
      checks++;
      if (Redirect_PC_E !== e_rd[i]) begin
        errors++;
        $display("FAIL mp%0d redirect: got %h want %h", i, Redirect_PC_E, e_rd[i]);
      end
    end
    Update_En_E = 1'b0;
    Predict_Taken_E = 1'b0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    Update_En_E = 1'b1; PC_E = 32'h80; Branch_Taken_E = 1'b1; PC_Target_E = 32'h300;
    look("rw_same_cycle_old", 32'h80, 1'b0, 32'h0);
    tick();
    Update_En_E = 1'b0;
    look("rw_next_cycle_new", 32'h80, 1'b1, 32'h300);
  endtask

  task automatic test_reset_priority();
    RST = 1'b1;
    upd(32'h140, 1'b1, 32'h400, 1'b0, 32'h0);
    RST = 1'b0;
    look("rst_prio_140", 32'h140, 1'b0, 32'h0);
    look("rst_clears_80", 32'h80, 1'b0, 32'h0);
  endtask

`ifdef BPU_STATS_EN
  task automatic test_stats();
    do_reset();
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    upd(32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
    upd(32'hC0, 1'b1, 32'h200, 1'b1, 32'h200);
    checks++;
    if (Branch_Count !== 32'd5) begin
      errors++;
      $display("FAIL stats_branch: got %0d want 5", Branch_Count);
    end
    checks++;
    if (Mispredict_Count !== 32'd2) begin
      errors++;
      $display("FAIL stats_mispredict: got %0d want 2", Mispredict_Count);
    end
    do_reset();
    checks++;
    if (Branch_Count !== 32'd0 || Mispredict_Count !== 32'd0) begin
      errors++;
      $display("FAIL stats_reset: got %0d/%0d want 0/0", Branch_Count, Mispredict_Count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_allocate();
    test_saturation();
    test_aliasing();
    test_mispredict();
    test_same_cycle();
    test_reset_priority();
`ifdef BPU_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
